// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 widths, schedule FSM states, sigma helpers and K table
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int T_W         = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Round constants, consumed by the compression stage alongside t_idx.
    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_sched_sigma.sv
// rtl/sha256_sched_sigma.sv - combinational W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w_m2,
    input  logic [WORD_W-1:0] w_m7,
    input  logic [WORD_W-1:0] w_m15,
    input  logic [WORD_W-1:0] w_m16,
    output logic [WORD_W-1:0] w_new
);

    assign w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule expander on a 16-entry in-place ring
// Optional running XOR of emitted words on sched_xor when SHA256_SCHED_CHECKSUM_EN is defined.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_word,
    output logic              load_ready,
    input  logic              w_ready,
    output logic              w_valid,
    output logic [WORD_W-1:0] w_t,
    output logic [T_W-1:0]    t_idx,
    output logic              busy,
`ifdef SHA256_SCHED_CHECKSUM_EN
    output logic [WORD_W-1:0] sched_xor,
`endif
    output logic              done
);

    localparam logic [T_W-1:0] LAST_T = T_W'(ROUNDS - 1);

    sched_state_e      state_q, state_d;
    logic [WORD_W-1:0] ring [BLOCK_WORDS];
    logic [3:0]        cnt_q;
    logic [T_W-1:0]    t_q;
    logic [3:0]        idx_t, idx_m2, idx_m7, idx_m15;
    logic [WORD_W-1:0] expanded;
    logic [WORD_W-1:0] w_word;
    logic              load_acc;
    logic              xfer;
    logic              block_start;
    logic              in_expand;

    // Ring slot t%16 still holds W[t-16] until this word is written back.
    assign idx_t   = t_q[3:0];
    assign idx_m2  = idx_t - 4'd2;
    assign idx_m7  = idx_t - 4'd7;
    assign idx_m15 = idx_t - 4'd15;

    sha256_sched_sigma u_sigma (
        .w_m2  (ring[idx_m2]),
        .w_m7  (ring[idx_m7]),
        .w_m15 (ring[idx_m15]),
        .w_m16 (ring[idx_t]),
        .w_new (expanded)
    );

    assign w_word      = (t_q[5:4] == 2'b00) ? ring[idx_t] : expanded;
    assign in_expand   = (state_q == EXPAND);
    assign load_acc    = (state_q == LOAD) && load_valid;
    assign xfer        = in_expand && w_ready;
    assign block_start = (state_q == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        w_valid    = 1'b0;
        w_t        = '0;
        t_idx      = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && cnt_q == 4'd15) state_d = EXPAND;
            end
            EXPAND: begin
                w_valid = 1'b1;
                w_t     = w_word;
                t_idx   = t_q;
                if (w_ready && t_q == LAST_T) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLOCK_WORDS; i++) ring[i] <= '0;
            cnt_q <= '0;
            t_q   <= '0;
        end else begin
            if (block_start) cnt_q <= '0;
            if (load_acc) begin
                ring[cnt_q] <= load_word;
                cnt_q       <= cnt_q + 4'd1;
                if (cnt_q == 4'd15) t_q <= '0;
            end
            if (xfer) begin
                if (t_q[5:4] != 2'b00) ring[idx_t] <= w_word;
                t_q <= t_q + T_W'(1);
            end
        end
    end

`ifdef SHA256_SCHED_CHECKSUM_EN
    logic [WORD_W-1:0] xor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_q <= '0;
        end else if (block_start) begin
            xor_q <= '0;
        end else if (xfer) begin
            xor_q <= xor_q ^ w_word;
        end
    end

    assign sched_xor = xor_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_valid;
    logic [31:0] load_word;
    logic        load_ready;
    logic        w_ready;
    logic        w_valid;
    logic [31:0] w_t;
    logic [5:0]  t_idx;
    logic        busy;
    logic        done;
`ifdef SHA256_SCHED_CHECKSUM_EN
    logic [31:0] sched_xor;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] cap   [64];
    int          cyc;

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_word  (load_word),
        .load_ready (load_ready),
        .w_ready    (w_ready),
        .w_valid    (w_valid),
        .w_t        (w_t),
        .t_idx      (t_idx),
        .busy       (busy),
`ifdef SHA256_SCHED_CHECKSUM_EN
        .sched_xor  (sched_xor),
`endif
        .done       (done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref();
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            ref_w[i] = ss1(ref_w[i-2]) + ref_w[i-7] + ss0(ref_w[i-15]) + ref_w[i-16];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
        check({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_w_t"}, w_t, 32'd0);
        check({tag, "_t_idx"}, {26'd0, t_idx}, 32'd0);
    endtask

    task automatic feed_words(input int gap);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                load_valid = 1'b0;
                tick();
                check("load_ready_gap", {31'd0, load_ready}, 32'd1);
            end
            load_valid = 1'b1;
            load_word  = blk[i];
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic load_block(input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready_on", {31'd0, load_ready}, 32'd1);
`ifdef SHA256_SCHED_CHECKSUM_EN
        check("xor_cleared", sched_xor, 32'd0);
`endif
        feed_words(gap);
    endtask

    task automatic run_expand(input bit toggle, input bit stray, input bit poke, input int stop_at,
                              output int cycles);
        int k;
        bit rdy;
        k = 0;
        rdy = 1'b1;
        cycles = 0;
        while (k < 64 && cycles < 400 && k != stop_at) begin
            check("w_valid", {31'd0, w_valid}, 32'd1);
            check("w_t", w_t, ref_w[k]);
            check("t_idx", {26'd0, t_idx}, k);
            if (stray) check("load_ready_expand", {31'd0, load_ready}, 32'd0);
            w_ready    = rdy;
            load_valid = stray & cycles[0];
            load_word  = 32'hdeadbeef;
            start      = poke & cycles[1];
            if (rdy) cap[k] = w_t;
            tick();
            cycles++;
            if (rdy) k++;
            if (toggle) rdy = ~rdy;
        end
        w_ready    = 1'b0;
        load_valid = 1'b0;
        start      = 1'b0;
        check("expand_count", k, (stop_at >= 0) ? stop_at : 64);
    endtask

    task automatic check_done();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_w_valid", {31'd0, w_valid}, 32'd0);
        check("done_t_idx", {26'd0, t_idx}, 32'd0);
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_ref();
    endtask

    initial begin
        logic [31:0] xor_exp;
        reset      = 1'b1;
        start      = 1'b0;
        load_valid = 1'b0;
        load_word  = 32'd0;
        w_ready    = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // Stray load_valid in IDLE must not start anything
        load_valid = 1'b1;
        load_word  = 32'h12345678;
        tick();
        load_valid = 1'b0;
        check_quiet("idle_stray");

        // Full-rate "abc" block
        set_abc();
        load_block(0);
        run_expand(1'b0, 1'b0, 1'b0, -1, cyc);
        check("full_rate_cycles", cyc, 64);
        check("abc_w16", cap[16], 32'h61626380);
        check("abc_w17", cap[17], 32'h000f0000);
        check("abc_w18", cap[18], 32'h7da86405);
        check("abc_w63", cap[63], 32'h12b1edeb);
        check_done();
`ifdef SHA256_SCHED_CHECKSUM_EN
        xor_exp = 32'd0;
        for (int i = 0; i < 64; i++) xor_exp ^= ref_w[i];
        check("xor_done", sched_xor, xor_exp);
`endif
        tick();
        check_quiet("after_done");
`ifdef SHA256_SCHED_CHECKSUM_EN
        check("xor_idle_hold", sched_xor, xor_exp);
`endif

        // Same block with w_ready toggling every cycle
        load_block(0);
        run_expand(1'b1, 1'b0, 1'b0, -1, cyc);
        check("stall_cycles", cyc, 127);
        check_done();
        tick();
        check_quiet("after_stall");

        // Gapped load plus stray load_valid during EXPAND
        load_block(2);
        run_expand(1'b0, 1'b1, 1'b0, -1, cyc);
        check_done();
        tick();

        // Reset in the middle of expansion, then an all-ones block
        load_block(0);
        run_expand(1'b0, 1'b0, 1'b0, 30, cyc);
        check("mid_t_idx", {26'd0, t_idx}, 32'd30);
        reset = 1'b1;
        #1;
        check_quiet("async_reset");
        tick();
        check_quiet("held_reset");
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) blk[i] = 32'hffffffff;
        build_ref();
        load_block(0);
        run_expand(1'b0, 1'b0, 1'b0, -1, cyc);
        check("ones_w16", cap[16], 32'h203ffffc);
        check_done();
        tick();

        // start pokes in EXPAND and DONE are ignored
        set_abc();
        load_block(0);
        run_expand(1'b0, 1'b0, 1'b1, -1, cyc);
        check_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_idle", {31'd0, busy}, 32'd0);
        tick();
        check_quiet("done_start_ignored");

        // start held high across DONE -> IDLE gives back-to-back blocks
        load_block(0);
        run_expand(1'b0, 1'b0, 1'b0, -1, cyc);
        check_done();
        start = 1'b1;
        tick();
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_idle_ready", {31'd0, load_ready}, 32'd0);
        tick();
        start = 1'b0;
        check("b2b_load_ready", {31'd0, load_ready}, 32'd1);
        feed_words(0);
        run_expand(1'b0, 1'b0, 1'b0, -1, cyc);
        check_done();
        tick();
        check_quiet("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
